mem_access_wb: RTL

//  Load/store access + writeback stage directly downstream of MEM. Consumes MEM's data_ce/we/addr/data and wb_data.

---
 rtl/mem_access_wb_pkg.sv | 26 ++
 rtl/mem_access_wb_lsu_align.sv | 70 +++++++
 rtl/mem_access_wb.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_wb_pkg
// Description : funct3 access-size codes and LSU state encoding shared by the
//               load/store + writeback stage and its alignment helper.
// Revision    : 1.0  initial release
// ============================================================================
package mem_access_wb_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_wb_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_wb_lsu_align (lsu_align)
// Description : Combinational legality check, byte-enable and store-lane
//               generation, plus load-data extraction and extension.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_wb_lsu_align
    import mem_access_wb_pkg::*;
(
    input  logic [2:0]                st_funct3_i,
    input  logic [1:0]                st_addr_lo_i,
    input  logic                      st_we_i,
    input  logic [REG_DATA_WIDTH-1:0] st_data_i,
    output logic                      legal_o,
    output logic [3:0]                be_o,
    output logic [REG_DATA_WIDTH-1:0] wdata_o,
    input  logic [2:0]                ld_funct3_i,
    input  logic [1:0]                ld_addr_lo_i,
    input  logic [REG_DATA_WIDTH-1:0] ld_rdata_i,
    output logic [REG_DATA_WIDTH-1:0] ld_data_o
);

    logic [REG_DATA_WIDTH-1:0] w_shifted;

    always_comb begin
        legal_o = 1'b0;
        be_o    = 4'b0000;
        wdata_o = st_data_i;
        case (st_funct3_i)
            LSU_B: begin
                legal_o = 1'b1;
                be_o    = 4'b0001 << st_addr_lo_i;
                wdata_o = {4{st_data_i[7:0]}};
            end
            LSU_H: begin
                legal_o = ~st_addr_lo_i[0];
                be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
                wdata_o = {2{st_data_i[15:0]}};
            end
            LSU_W: begin
                legal_o = (st_addr_lo_i == 2'b00);
                be_o    = 4'b1111;
            end
            // Unsigned variants only make sense for loads.
            LSU_BU: begin
                legal_o = ~st_we_i;
                be_o    = 4'b0001 << st_addr_lo_i;
            end
            LSU_HU: begin
                legal_o = ~st_we_i & ~st_addr_lo_i[0];
                be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
            end
            default: legal_o = 1'b0;
        endcase
    end

    always_comb begin
        w_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
        case (ld_funct3_i)
            LSU_B:   ld_data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LSU_H:   ld_data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LSU_BU:  ld_data_o = {24'd0, w_shifted[7:0]};
            LSU_HU:  ld_data_o = {16'd0, w_shifted[15:0]};
            default: ld_data_o = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_wb.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_wb
// Description : Load/store access + writeback stage. Runs a req/ack handshake
//               to a wait-stated data memory and drives the register-file port.
// Revision    : 1.0  initial release
// ============================================================================
module mem_access_wb
    import mem_access_wb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_ce_i,
    input  logic                      data_we_i,
    input  logic [2:0]                funct3_i,
    input  logic [REG_DATA_WIDTH-1:0] data_addr_i,
    input  logic [REG_DATA_WIDTH-1:0] data_i,
    input  logic [REG_DATA_WIDTH-1:0] wb_data_i,
    input  logic                      memtoreg_i,
    input  logic                      regwrite_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    output logic                      bus_req_o,
    output logic                      bus_we_o,
    output logic [3:0]                bus_be_o,
    output logic [REG_DATA_WIDTH-1:0] bus_addr_o,
    output logic [REG_DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                      bus_ack_i,
    input  logic [REG_DATA_WIDTH-1:0] bus_rdata_i,
    output logic                      stall_o,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [REG_DATA_WIDTH-1:0] rf_wdata_o,
    output logic                      err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [3:0]                be_q, be_d;
    logic [REG_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      tout_q, tout_d;

    logic                      w_legal;
    logic [3:0]                w_be;
    logic [REG_DATA_WIDTH-1:0] w_wdata;
    logic [REG_DATA_WIDTH-1:0] w_ld_data;
    logic                      w_rd_nz;

    mem_access_wb_lsu_align u_lsu_align (
        .st_funct3_i  (funct3_i),
        .st_addr_lo_i (data_addr_i[1:0]),
        .st_we_i      (data_we_i),
        .st_data_i    (data_i),
        .legal_o      (w_legal),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .ld_funct3_i  (funct3_q),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_rdata_i   (rdata_q),
        .ld_data_o    (w_ld_data)
    );

    assign w_rd_nz     = (rd_i != '0);
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_be_o    = be_q;
    assign bus_addr_o  = {addr_q[REG_DATA_WIDTH-1:2], 2'b00};
    assign bus_wdata_o = wdata_q;
    assign rf_waddr_o  = rd_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        rdata_d    = rdata_q;
        tout_d     = tout_q;
        stall_o    = 1'b0;
        rf_we_o    = 1'b0;
        rf_wdata_o = wb_data_i;
        err_o      = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (data_ce_i) begin
                    if (w_legal) begin
                        stall_o  = 1'b1;
                        state_d  = LSU_REQ;
                        req_d    = 1'b1;
                        we_d     = data_we_i;
                        be_d     = w_be;
                        addr_d   = data_addr_i;
                        wdata_d  = w_wdata;
                        funct3_d = funct3_i;
                        cnt_d    = '0;
                        tout_d   = 1'b0;
                    end else begin
                        err_o = 1'b1;
                    end
                end else begin
                    rf_we_o = regwrite_i & w_rd_nz;
                end
            end
            LSU_REQ: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    rdata_d = bus_rdata_i;
                    state_d = LSU_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th request cycle with no ack.
                    err_o   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = LSU_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
                if (!we_q && !tout_q) begin
                    rf_we_o    = regwrite_i & memtoreg_i & w_rd_nz;
                    rf_wdata_o = memtoreg_i ? w_ld_data : wb_data_i;
                end
            end
            default: state_d = LSU_IDLE;
        endcase

        // Nothing commits or stalls while the stage is being reset.
        if (rst) begin
            stall_o = 1'b0;
            rf_we_o = 1'b0;
            err_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LSU_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= 3'd0;
            rdata_q  <= '0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            tout_q   <= tout_d;
        end
    end

endmodule
`default_nettype wire
